// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAMHelper port between the instruction-fetch
// (read-only) and data (read/write) requesters; one registered transaction in flight.
module ram_arbiter #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] d_wmask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_ren,
    output logic [ADDR_W-1:0] ram_ridx,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_widx,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_wmask
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;
    typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_e;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    // Handshake: a requester holds req until it sees gnt in the same cycle; the
    // owner's rvalid then pulses for exactly one cycle two cycles after the grant.
    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] wmask_q, wmask_d;
    logic [ADDR_W-1:0] ram_idx;

    // Word index; the subtraction wraps and the byte offset bits fall away.
    assign ram_idx = (addr_q - BASE) >> 3;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        if_rvalid    = 1'b0;
        d_rvalid     = 1'b0;
        if_rdata     = '0;
        d_rdata      = '0;
        ram_ren      = 1'b0;
        ram_ridx     = '0;
        ram_wen      = 1'b0;
        ram_widx     = '0;
        ram_wdata    = '0;
        ram_wmask    = '0;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (d_req && (!if_req || last_owner_q == OWN_FETCH)) begin
                        d_gnt        = 1'b1;
                        owner_d      = OWN_DATA;
                        last_owner_d = OWN_DATA;
                        we_d         = d_we;
                        addr_d       = d_addr;
                        wdata_d      = d_wdata;
                        wmask_d      = d_wmask;
                        state_d      = ISSUE;
                    end else if (if_req) begin
                        if_gnt       = 1'b1;
                        owner_d      = OWN_FETCH;
                        last_owner_d = OWN_FETCH;
                        we_d         = 1'b0;
                        addr_d       = if_addr;
                        wdata_d      = '0;
                        wmask_d      = '0;
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    ram_wen   = 1'b1;
                    ram_widx  = ram_idx;
                    ram_wdata = wdata_q;
                    ram_wmask = wmask_q;
                end else begin
                    ram_ren  = 1'b1;
                    ram_ridx = ram_idx;
                end
                state_d = RESP;
            end
            RESP: begin
                // RAMHelper registers rdata, so it is valid now and passes straight through.
                if (owner_q == OWN_FETCH) begin
                    if_rvalid = 1'b1;
                    if_rdata  = ram_rdata;
                end else begin
                    d_rvalid = 1'b1;
                    d_rdata  = we_q ? '0 : ram_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_FETCH;
            last_owner_q <= OWN_FETCH;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

endmodule
